// File: rtl/wave_lcd_scan_ctrl.sv
// Purpose : scans the 5-bank 1bpp wave map out of RAM once per completed frame and turns it into an RGB565 pixel stream.
// Latency : a read address is registered the cycle after it is issued, and its pixel reaches the stream head two cycles later.
// Backpr. : pix_ready stalls pix_valid/pix_data/pix_sof/pix_eol in place, and a read issues only when a FIFO slot is guaranteed.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   ram_ready         RAM frame is complete and readable
//   ram_data_i        RAM read data; bit0 is the map pixel, valid one cycle after the address
//   lcd_ram_addr      read address {y[7:0], x[5:0]}
//   lcd_ram_en        one-hot bank select, decoded from x[8:6]
//   lcd_refreshing    high while the scan owns the RAM (SCAN and DRAIN)
//   pix_data/valid/ready/sof/eol   pixel stream to the LCD driver
//   frame_cnt         count of completed frames; wraps
//
// Build option: define WAVE_GRID_EN to draw a GRID_COLOR graticule on background pixels.
module wave_lcd_scan_ctrl #(
    parameter int          H_PIXELS   = 320,
    parameter int          V_LINES    = 256,
    parameter logic [15:0] FG_COLOR   = 16'hFFE0,
    parameter logic [15:0] BG_COLOR   = 16'h0000,
    parameter logic [15:0] GRID_COLOR = 16'h4208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ready,
    input  logic [15:0] ram_data_i,
    output logic [13:0] lcd_ram_addr,
    output logic [4:0]  lcd_ram_en,
    output logic        lcd_refreshing,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [15:0] frame_cnt
);

    localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
    localparam logic [7:0] Y_TOP  = 8'(V_LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [8:0]  r_x;
    logic [7:0]  r_y;
    logic        r_hold;
    logic [13:0] r_addr;
    logic [4:0]  r_en;
    logic        r_refreshing;
    logic [15:0] r_frame_cnt;

    // Stage 1: address on the RAM pins. Stage 2: RAM data on ram_data_i.
    logic        r_s1_vld, r_s1_sof, r_s1_eol, r_s1_last;
    logic        r_s2_vld, r_s2_sof, r_s2_eol, r_s2_last;
`ifdef WAVE_GRID_EN
    logic        r_s1_grid, r_s2_grid;
    logic        w_grid;
`endif

    // 2-entry pixel FIFO
    logic [15:0] r_mem_dat [2];
    logic [1:0]  r_mem_sof;
    logic [1:0]  r_mem_eol;
    logic [1:0]  r_mem_last;
    logic        r_wp, r_rp;
    logic [1:0]  r_cnt;

    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_issue;
    logic        w_last_x;
    logic        w_last_issue;
    logic [15:0] w_push_dat;
    logic        w_unused;

    assign w_last_x     = (r_x == X_LAST);
    assign w_last_issue = w_last_x && (r_y == 8'd0);
    assign w_pop        = pix_valid && pix_ready;

    // Occupancy counts every read still in the pipe plus the FIFO contents
    // left after this cycle's pop. A new read may go out only when it is
    // guaranteed a slot when it lands, so data is never dropped.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_s1_vld} + {2'b00, r_s2_vld} - {2'b00, w_pop};
    assign w_issue = (r_state == S_SCAN) && (w_occ < 3'd2);

`ifdef WAVE_GRID_EN
    assign w_grid     = (r_x[4:0] == 5'd0) || (r_y[4:0] == 5'd0) || w_last_x;
    assign w_push_dat = ram_data_i[0] ? FG_COLOR : (r_s2_grid ? GRID_COLOR : BG_COLOR);
`else
    assign w_push_dat = ram_data_i[0] ? FG_COLOR : BG_COLOR;
`endif

    assign w_unused = ^{ram_data_i[15:1], GRID_COLOR};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_hold       <= 1'b0;
            r_addr       <= '0;
            r_en         <= '0;
            r_refreshing <= 1'b0;
            r_frame_cnt  <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_sof     <= 1'b0;
            r_s1_eol     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s2_sof     <= 1'b0;
            r_s2_eol     <= 1'b0;
            r_s2_last    <= 1'b0;
`ifdef WAVE_GRID_EN
            r_s1_grid    <= 1'b0;
            r_s2_grid    <= 1'b0;
`endif
            r_mem_dat[0] <= '0;
            r_mem_dat[1] <= '0;
            r_mem_sof    <= '0;
            r_mem_eol    <= '0;
            r_mem_last   <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            // Read pipeline. Tags travel with each read.
            r_s1_vld <= w_issue;
            if (w_issue) begin
                r_s1_sof  <= (r_x == 9'd0) && (r_y == Y_TOP);
                r_s1_eol  <= w_last_x;
                r_s1_last <= w_last_issue;
`ifdef WAVE_GRID_EN
                r_s1_grid <= w_grid;
`endif
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_sof  <= r_s1_sof;
            r_s2_eol  <= r_s1_eol;
            r_s2_last <= r_s1_last;
`ifdef WAVE_GRID_EN
            r_s2_grid <= r_s1_grid;
`endif

            // FIFO
            if (r_s2_vld) begin
                r_mem_dat[r_wp]  <= w_push_dat;
                r_mem_sof[r_wp]  <= r_s2_sof;
                r_mem_eol[r_wp]  <= r_s2_eol;
                r_mem_last[r_wp] <= r_s2_last;
                r_wp             <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, r_s2_vld} - {1'b0, w_pop};

            if (w_pop && r_mem_last[r_rp]) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (ram_ready) begin
                        r_state      <= S_SCAN;
                        r_refreshing <= 1'b1;
                        r_x          <= '0;
                        r_y          <= Y_TOP;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        r_addr <= {r_y, r_x[5:0]};
                        r_en   <= 5'b00001 << r_x[8:6];
                        if (w_last_x) begin
                            r_x <= '0;
                            r_y <= r_y - 8'd1;
                        end else begin
                            r_x <= r_x + 9'd1;
                        end
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait until the last pixel has left the FIFO and nothing is in flight.
                    if ((r_cnt == 2'd0) && !r_s1_vld && !r_s2_vld) begin
                        r_state      <= S_RELEASE;
                        r_refreshing <= 1'b0;
                        r_en         <= '0;
                        r_addr       <= '0;
                        r_hold       <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    // lcd_refreshing stays low at least two cycles so the RAM's
                    // 2-stage edge detector sees the release. Waiting for
                    // ram_ready=0 stops the same frame from being scanned twice.
                    if (!r_hold) begin
                        r_hold <= 1'b1;
                    end else if (!ram_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lcd_ram_addr   = r_addr;
    assign lcd_ram_en     = r_en;
    assign lcd_refreshing = r_refreshing;
    assign frame_cnt      = r_frame_cnt;
    assign pix_valid      = (r_cnt != 2'd0);
    assign pix_data       = pix_valid ? r_mem_dat[r_rp] : 16'h0000;
    assign pix_sof        = pix_valid && r_mem_sof[r_rp];
    assign pix_eol        = pix_valid && r_mem_eol[r_rp];

endmodule

// File: tb/tb_wave_lcd_scan_ctrl.sv
// Directed bench for wave_lcd_scan_ctrl.
// The frame height is shortened to 4 lines to keep the run short, and the line width stays at 320 so every bank boundary is exercised.
// The map holds a 1 only on line y=MAP_Y, which is output line index V-1-MAP_Y.
module tb_wave_lcd_scan_ctrl;

    localparam int          H      = 320;
    localparam int          V      = 4;
    localparam int          NPIX   = H * V;
    localparam int          MAP_Y  = 2;
    localparam logic [15:0] FG     = 16'hFFE0;
    localparam logic [15:0] BG     = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_ready = 1'b0;
    logic [15:0] ram_data_i = '0;
    logic [13:0] lcd_ram_addr;
    logic [4:0]  lcd_ram_en;
    logic        lcd_refreshing;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof;
    logic        pix_eol;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] px_dat[$];
    bit          px_sof[$];
    bit          px_eol[$];
    logic [18:0] iss_key[$];
    logic [15:0] ref_dat[$];

    wave_lcd_scan_ctrl #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .rst(rst), .ram_ready(ram_ready), .ram_data_i(ram_data_i),
        .lcd_ram_addr(lcd_ram_addr), .lcd_ram_en(lcd_ram_en), .lcd_refreshing(lcd_refreshing),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: one cycle read latency, random junk above bit0.
    always @(posedge clk) begin
        ram_data_i <= {15'($urandom), (lcd_ram_addr[13:6] == 8'(MAP_Y))};
    end

    function automatic logic [15:0] exp_dat(int k);
        return ((V - 1 - k / H) == MAP_Y) ? FG : BG;
    endfunction

    function automatic logic [18:0] exp_key(int k);
        logic [4:0] e;
        int x;
        x = k % H;
        e = 5'b00001 << (x / 64);
        return {e, 8'(V - 1 - k / H), 6'(x % 64)};
    endfunction

    // Runs cycles, recording issued addresses and accepted pixels, until
    // lcd_refreshing falls or stop_px pixels have been accepted.
    task automatic run_frame(input bit rnd, input int stop_px, input int drop_at, output bit timeout);
        bit          seen_hi, prev_stall, ps, pe;
        logic [15:0] pd;
        logic [18:0] prev_key;
        px_dat.delete(); px_sof.delete(); px_eol.delete(); iss_key.delete();
        seen_hi = lcd_refreshing; prev_stall = 0; prev_key = '0; pd = '0; ps = 0; pe = 0;
        timeout = 1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_at >= 0 && px_dat.size() >= drop_at) ram_ready = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (pix_valid !== 1'b1 || pix_data !== pd || pix_sof !== ps || pix_eol !== pe) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%h s=%b e=%b, required v=1 d=%h s=%b e=%b",
                             pix_valid, pix_data, pix_sof, pix_eol, pd, ps, pe);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            pd = pix_data; ps = pix_sof; pe = pix_eol;
            if (lcd_ram_en != 5'd0 && {lcd_ram_en, lcd_ram_addr} != prev_key)
                iss_key.push_back({lcd_ram_en, lcd_ram_addr});
            prev_key = {lcd_ram_en, lcd_ram_addr};
            if (pix_valid && pix_ready) begin
                px_dat.push_back(pix_data); px_sof.push_back(pix_sof); px_eol.push_back(pix_eol);
            end
            if (lcd_refreshing) seen_hi = 1;
            if (seen_hi && !lcd_refreshing) begin timeout = 0; break; end
            if (stop_px > 0 && px_dat.size() >= stop_px) begin timeout = 0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ram_ready = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (lcd_refreshing !== 1'b0) begin n_fail++; $display("FAIL rst_refreshing: got %b required 0", lcd_refreshing); end
        n_checks++; if (lcd_ram_en !== 5'd0) begin n_fail++; $display("FAIL rst_en: got %b required 00000", lcd_ram_en); end
        n_checks++; if (lcd_ram_addr !== 14'd0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", lcd_ram_addr); end
        n_checks++; if (pix_valid !== 1'b0 || pix_sof !== 1'b0 || pix_eol !== 1'b0) begin n_fail++; $display("FAIL rst_pix_flags: got v=%b s=%b e=%b required 0", pix_valid, pix_sof, pix_eol); end
        n_checks++; if (pix_data !== 16'd0) begin n_fail++; $display("FAIL rst_pix_data: got %h required 0", pix_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
        @(posedge clk); #1; rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (lcd_refreshing !== 1'b0) begin n_fail++; $display("FAIL idle_no_ready: got %b required 0", lcd_refreshing); end
    endtask

    task automatic test_full_frame();
        bit to;
        int e;
        @(posedge clk); #1; ram_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (lcd_refreshing !== 1'b0) begin n_fail++; $display("FAIL refresh_same_cycle: got %b required 0", lcd_refreshing); end
        @(negedge clk);
        n_checks++; if (lcd_refreshing !== 1'b1) begin n_fail++; $display("FAIL refresh_rise: got %b required 1", lcd_refreshing); end
        run_frame(0, 0, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL frame1_timeout: got timeout required frame end"); end
        n_checks++; if (px_dat.size() != NPIX) begin n_fail++; $display("FAIL frame1_px_count: got %0d required %0d", px_dat.size(), NPIX); end
        e = 0;
        for (int k = 0; k < px_dat.size() && k < NPIX; k++)
            if (px_dat[k] !== exp_dat(k) || px_sof[k] !== (k == 0) || px_eol[k] !== (k % H == H - 1)) e++;
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL frame1_pixels: got %0d bad pixels required 0", e); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL frame1_cnt: got %0d required 1", frame_cnt); end
        n_checks++; if (iss_key.size() != NPIX) begin n_fail++; $display("FAIL frame1_reads: got %0d required %0d", iss_key.size(), NPIX); end
        e = 0;
        for (int k = 0; k < iss_key.size() && k < NPIX; k++)
            if (iss_key[k] !== exp_key(k)) e++;
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL frame1_addr_seq: got %0d bad reads required 0", e); end
        ref_dat = px_dat;
    endtask

    task automatic test_bank_boundaries();
        if (iss_key.size() < 321) begin
            n_checks++; n_fail++;
            $display("FAIL bank_reads: got %0d reads required at least 321", iss_key.size());
        end else begin
            n_checks++; if (iss_key[63][18:14] !== 5'b00001 || iss_key[64][18:14] !== 5'b00010) begin n_fail++; $display("FAIL bank_63_64: got %b->%b required 00001->00010", iss_key[63][18:14], iss_key[64][18:14]); end
            n_checks++; if (iss_key[63][5:0] !== 6'd63 || iss_key[64][5:0] !== 6'd0) begin n_fail++; $display("FAIL xfield_wrap: got %0d->%0d required 63->0", iss_key[63][5:0], iss_key[64][5:0]); end
            n_checks++; if (iss_key[255][18:14] !== 5'b01000 || iss_key[256][18:14] !== 5'b10000) begin n_fail++; $display("FAIL bank_255_256: got %b->%b required 01000->10000", iss_key[255][18:14], iss_key[256][18:14]); end
            n_checks++; if (iss_key[320] !== {5'b00001, 8'(V - 2), 6'd0}) begin n_fail++; $display("FAIL line_wrap: got %h required %h", iss_key[320], {5'b00001, 8'(V - 2), 6'd0}); end
        end
        n_checks++; if (px_dat.size() < 320 || px_eol[319] !== 1'b1 || px_eol[318] !== 1'b0) begin n_fail++; $display("FAIL eol_at_319: got eol mismatch near x=319 required eol only at x=319"); end
    endtask

    task automatic test_no_rescan();
        int e = 0;
        repeat (30) begin
            @(negedge clk);
            if (lcd_refreshing !== 1'b0 || lcd_ram_en !== 5'd0 || pix_valid !== 1'b0) e++;
        end
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL no_rescan: got %0d active cycles required 0", e); end
        @(posedge clk); #1; ram_ready = 1'b0;
        @(posedge clk); #1; ram_ready = 1'b1;
        e = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lcd_refreshing) begin e = 0; break; end
        end
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL rescan_after_toggle: got no rise required lcd_refreshing=1"); end
    endtask

    task automatic test_backpressure();
        bit to;
        int e = 0;
        run_frame(1, 0, 500, to);
        n_checks++; if (to || px_dat.size() != NPIX) begin n_fail++; $display("FAIL bp_px_count: got %0d (timeout=%b) required %0d", px_dat.size(), to, NPIX); end
        for (int k = 0; k < px_dat.size() && k < ref_dat.size(); k++)
            if (px_dat[k] !== ref_dat[k] || px_sof[k] !== (k == 0) || px_eol[k] !== (k % H == H - 1)) e++;
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL bp_pixels: got %0d bad pixels required 0", e); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d required 2", frame_cnt); end
    endtask

    task automatic test_release_hold();
        int  low = 1;
        bit  rose = 0;
        pix_ready = 1'b1;
        @(posedge clk); #1; ram_ready = 1'b0;
        @(negedge clk); if (!lcd_refreshing) low++;
        @(posedge clk); #1; ram_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_refreshing) begin rose = 1; break; end
            low++;
        end
        n_checks++; if (!rose || low < 2) begin n_fail++; $display("FAIL release_low: got %0d low cycles (rose=%b) required >=2 and rise", low, rose); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int e = 0;
        run_frame(0, 400, -1, to);
        n_checks++; if (to || px_dat.size() != 400) begin n_fail++; $display("FAIL mid_progress: got %0d pixels required 400", px_dat.size()); end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (lcd_refreshing !== 1'b0 || lcd_ram_en !== 5'd0 || lcd_ram_addr !== 14'd0 || pix_valid !== 1'b0 ||
            pix_data !== 16'd0 || pix_sof !== 1'b0 || pix_eol !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got r=%b en=%b a=%h v=%b d=%h s=%b e=%b f=%0d required all 0",
                     lcd_refreshing, lcd_ram_en, lcd_ram_addr, pix_valid, pix_data, pix_sof, pix_eol, frame_cnt);
        end
        @(posedge clk); #1; rst = 1'b1;
        run_frame(0, 0, -1, to);
        n_checks++; if (iss_key.size() == 0 || iss_key[0] !== {5'b00001, 8'(V - 1), 6'd0}) begin n_fail++; $display("FAIL restart_first_read: got %h required %h", (iss_key.size() != 0) ? iss_key[0] : 19'h0, {5'b00001, 8'(V - 1), 6'd0}); end
        n_checks++; if (px_dat.size() == 0 || px_sof[0] !== 1'b1) begin n_fail++; $display("FAIL restart_sof: got no sof on first pixel required sof"); end
        for (int k = 0; k < px_dat.size() && k < NPIX; k++)
            if (px_dat[k] !== exp_dat(k)) e++;
        n_checks++; if (to || px_dat.size() != NPIX || e != 0) begin n_fail++; $display("FAIL restart_frame: got %0d pixels, %0d bad, required %0d, 0 bad", px_dat.size(), e, NPIX); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL restart_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_bank_boundaries();
        test_no_rescan();
        test_backpressure();
        test_release_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
